// File: rtl/core_share_arbiter.sv
// core_share_arbiter: round-robin front-end that time-shares one combinational core.
// Each accepted request drives the core inputs, waits SETTLE cycles, captures the
// core outputs and returns them tagged with the requester index over a valid/ready
// response channel. Optional MISR signature over captured outputs: `define CORE_MISR_EN.
module core_share_arbiter #(
  parameter int NREQ   = 4,
  parameter int IN_W   = 14,
  parameter int OUT_W  = 8,
  parameter int SETTLE = 2,
  parameter int ID_W   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*IN_W-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [IN_W-1:0]      core_in,
  input  logic [OUT_W-1:0]     core_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [OUT_W-1:0]     rsp_data,
`ifdef CORE_MISR_EN
  input  logic                 misr_clr,
  output logic [OUT_W-1:0]     misr_sig,
`endif
  output logic                 busy
);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  if (SETTLE < 1) begin : g_bad_settle
    $error("core_share_arbiter: SETTLE must be >= 1");
  end
  if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
    $error("core_share_arbiter: NREQ must be in 2..16");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;

  state_t            r_state, w_next;
  logic [ID_W-1:0]   r_ptr, w_win, r_rsp_id;
  logic              w_found, w_accept, w_capture, w_done, r_rsp_valid;
  logic [CW-1:0]     r_cnt;
  logic [IN_W-1:0]   r_core_in;
  logic [OUT_W-1:0]  r_rsp_data;

  // Winner: first valid requester at or above ptr, wrapping modulo NREQ.
  always_comb begin : p_pick
    int t;
    t       = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      t = int'(r_ptr) + k;
      if (t >= NREQ) t = t - NREQ;
      if (!w_found && req_valid[t[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = t[ID_W-1:0];
      end
    end
  end

  // Next-state and the combinational accept strobe.
  always_comb begin
    w_accept  = (r_state == S_IDLE) && w_found;
    w_capture = (r_state == S_SETTLE) && (r_cnt == '0);
    w_done    = (r_state == S_RESP) && rsp_ready;
    w_next    = w_accept ? S_SETTLE : w_capture ? S_RESP : w_done ? S_IDLE : r_state;
    req_ready = w_accept ? (NREQ'(1) << w_win) : '0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Datapath: latch the winner onto the core, count settle cycles, capture and hand back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_core_in   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      if (w_accept) begin
        r_core_in <= req_data[int'(w_win)*IN_W +: IN_W];
        r_rsp_id  <= w_win;
        r_cnt     <= CW'(SETTLE - 1);
        r_ptr     <= (w_win == ID_W'(NREQ - 1)) ? '0 : w_win + 1'b1;
      end
      if (r_state == S_SETTLE && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (w_capture) begin
        r_rsp_data  <= core_out;
        r_rsp_valid <= 1'b1;
      end
      if (w_done) r_rsp_valid <= 1'b0;
    end
  end

`ifdef CORE_MISR_EN
  if (OUT_W != 8) begin : g_bad_misr
    $error("core_share_arbiter: MISR requires OUT_W == 8");
  end

  logic [OUT_W-1:0] r_misr;
  logic             w_fb;

  assign w_fb = r_misr[7] ^ r_misr[5] ^ r_misr[4] ^ r_misr[3];

  // Signature folds every captured core result; clear wins over update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_misr <= '0;
    else if (misr_clr)  r_misr <= '0;
    else if (w_capture) r_misr <= {r_misr[OUT_W-2:0], w_fb} ^ core_out;
  end

  assign misr_sig = r_misr;
`endif

  assign core_in   = r_core_in;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != S_IDLE);
endmodule

// File: doc/core_share_arbiter.md
# core_share_arbiter

Sequential front-end that shares one instance of a synthesized combinational benchmark core (14 inputs, 8 outputs, gate-level netlist with multi-gate-delay paths) between several requesters. It arbitrates round-robin, registers the winning input vector onto the core, waits a programmable number of settle cycles, and captures the core outputs. It then returns the captured result with the requester ID over a valid/ready response channel. It sits between the optimized netlist and the evaluation harness that drives candidate designs.

## Interface
- NREQ, 4, number of requesters (2..16)
- IN_W, 14, core input width
- OUT_W, 8, core output width
- SETTLE, 2, cycles the core input is held before capture (>=1; elaboration error if 0)
- ID_W, derived, $clog2(NREQ)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_data  in  NREQ*IN_W  request vectors, requester i at [i*IN_W +: IN_W]
- req_ready  out  NREQ  one-hot grant/accept, combinational
- core_in  out  IN_W  registered drive to core inputs
- core_out  in  OUT_W  core outputs (combinational from core_in)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_id  out  ID_W  index of requester served
- rsp_data  out  OUT_W  captured core_out
- busy  out  1  high in SETTLE and RESP

Decided: one clock; reset is asynchronous and active-low (clk, rst_n).

## Operation
- FSM states: IDLE, SETTLE, RESP.
- IDLE: if any req_valid, winner = first set bit searching upward from ptr, wrapping modulo NREQ. req_ready[winner]=1 same cycle (accept). At edge: core_in<=req_data[winner], rsp_id<=winner, cnt<=SETTLE-1, ptr<=(winner+1) mod NREQ, ->SETTLE. No valid: stay, req_ready=0.
- SETTLE: cnt!=0 -> cnt--. cnt==0 -> rsp_data<=core_out, rsp_valid<=1, ->RESP.
- RESP: rsp_valid held with stable rsp_id/rsp_data until rsp_ready; at handshake edge rsp_valid<=0, ->IDLE.
- req_ready is zero outside IDLE; at most one bit set. Requesters hold req_valid/req_data until accepted; the block never drops an accepted request except on reset.
- core_in holds its last value between transactions (no toggling).
- busy = (state!=IDLE).

## Timing
- Reset values: state IDLE, ptr 0, cnt 0, core_in 0, rsp_valid 0, rsp_id 0, rsp_data 0, busy 0, req_ready 0.
- Accept edge at cycle t: core_in valid from t+1; rsp_valid high from t+SETTLE+1 (visible SETTLE cycles after core_in changes).
- Minimum transaction period with rsp_ready tied high: SETTLE+2 cycles (IDLE, SETTLE×SETTLE, RESP).
- rsp_ready asserted before rsp_valid has no effect.
- Simultaneous requests: exactly one accepted per IDLE visit; others wait. With all valid, grants cycle 0,1,…,NREQ-1,0.
- ptr wraps from NREQ-1 to 0.
- Reset mid-transaction: immediate return to reset values; the in-flight request produces no response, and the requester re-presents.

## Configuration
- CORE_MISR_EN defined: adds ports misr_clr (in, 1, synchronous clear) and misr_sig (out, OUT_W, reset 0). On each capture edge misr_sig <= {misr_sig[OUT_W-2:0], fb} ^ core_out, with fb = misr_sig[7]^misr_sig[5]^misr_sig[4]^misr_sig[3] (OUT_W=8; OUT_W!=8 is an elaboration error). misr_clr has priority over update.
- Undefined: ports absent and no MISR logic; all other behaviour is identical.

## Test plan
- Reset then single request: req_valid=4'b0100, data=14'h1A5B, core model out=8'h3C, SETTLE=2 -> req_ready=4'b0100 in accept cycle, rsp_valid high 3 cycles after accept edge, rsp_id=2, rsp_data=8'h3C.
- All four valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0, one response every 4 cycles.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_data stable, req_ready=0, busy=1 throughout; ready pulse -> IDLE next cycle.
- Wrap: ptr=3, req_valid=4'b1001 -> grant 3, then grant 0.
- rst_n low during SETTLE -> all outputs at reset values asynchronously, no response after release.
- CORE_MISR_EN: captures 8'h01 then 8'h02 from cleared state -> misr_sig 8'h01, then 8'h00.
